// File: rtl/ro_pair_counter_if.sv
// Control/result bundle for the ring-oscillator pair counter.
// Master requests a measurement; slave reports counts and flags.
interface ro_pair_counter_if #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
);
    logic             start;
    logic [WIN_W-1:0] window;
    logic             busy;
    logic             done;
    logic             response;
    logic             tie;
    logic             sat;
    logic [CNT_W-1:0] count_a;
    logic [CNT_W-1:0] count_b;

    modport master (
        output start,
        output window,
        input  busy,
        input  done,
        input  response,
        input  tie,
        input  sat,
        input  count_a,
        input  count_b
    );

    modport slave (
        input  start,
        input  window,
        output busy,
        output done,
        output response,
        output tie,
        output sat,
        output count_a,
        output count_b
    );
endinterface

// File: rtl/ro_pair_counter.sv
// Ring-oscillator pair edge counter: gates both oscillators, counts
// synchronized rising edges over a window and compares the totals.
module ro_pair_counter #(
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 16,
    parameter int SETTLE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ro_a_in,
    input  logic i_ro_b_in,
    output logic o_ro_enable,
    ro_pair_counter_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_COUNT  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [WIN_W-1:0] L_SETTLE_LAST = WIN_W'(SETTLE - 1);
    localparam logic [WIN_W-1:0] L_ONE         = WIN_W'(1);
    localparam logic [CNT_W-1:0] L_CNT_ONE     = CNT_W'(1);

    logic [1:0]       r_state;
    logic [WIN_W-1:0] r_timer;
    logic [WIN_W-1:0] r_window;
    logic [2:0]       r_sync_a;
    logic [2:0]       r_sync_b;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;
    logic             r_sat;
    logic             r_tie;
    logic             r_resp;

    logic             w_counting;
    logic             w_edge_a;
    logic             w_edge_b;
    logic             w_max_a;
    logic             w_max_b;
    logic             w_inc_a;
    logic             w_inc_b;
    logic [CNT_W-1:0] w_next_a;
    logic [CNT_W-1:0] w_next_b;
    logic             w_sat_hit;
    logic             w_settle_end;
    logic             w_count_end;

    // Bit 0 is the first capture flop; edge taken between stages 2 and 3.
    assign w_edge_a   = r_sync_a[1] & ~r_sync_a[2];
    assign w_edge_b   = r_sync_b[1] & ~r_sync_b[2];
    assign w_counting = (r_state == S_COUNT);

    assign w_max_a  = &r_cnt_a;
    assign w_max_b  = &r_cnt_b;
    assign w_inc_a  = w_counting & w_edge_a;
    assign w_inc_b  = w_counting & w_edge_b;
    assign w_next_a = (w_inc_a && !w_max_a) ? r_cnt_a + L_CNT_ONE : r_cnt_a;
    assign w_next_b = (w_inc_b && !w_max_b) ? r_cnt_b + L_CNT_ONE : r_cnt_b;
    assign w_sat_hit = (w_inc_a & w_max_a) | (w_inc_b & w_max_b);

    assign w_settle_end = (r_timer == L_SETTLE_LAST);
    assign w_count_end  = (r_timer == r_window - L_ONE);

    // Free-running synchronizers for the asynchronous oscillator lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_a <= 3'b000;
            r_sync_b <= 3'b000;
        end else begin
            r_sync_a <= {r_sync_a[1:0], i_ro_a_in};
            r_sync_b <= {r_sync_b[1:0], i_ro_b_in};
        end
    end

    // Measurement sequencer: idle, settle, count window, report.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_window <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state  <= S_SETTLE;
                        r_timer  <= '0;
                        r_window <= bus.window;
                    end
                end
                S_SETTLE: begin
                    if (w_settle_end) begin
                        r_timer <= '0;
                        r_state <= (r_window == '0) ? S_DONE : S_COUNT;
                    end else begin
                        r_timer <= r_timer + L_ONE;
                    end
                end
                S_COUNT: begin
                    if (w_count_end) begin
                        r_timer <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_timer <= r_timer + L_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Edge counters and saturation flag; cleared when a start is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
            r_sat   <= 1'b0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_cnt_a <= w_next_a;
            r_cnt_b <= w_next_b;
            if (w_sat_hit) begin
                r_sat <= 1'b1;
            end
        end
    end

    // Comparison result captured from the final counts on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tie  <= 1'b0;
            r_resp <= 1'b0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_tie  <= 1'b0;
            r_resp <= 1'b0;
        end else if ((r_state == S_COUNT && w_count_end) ||
                     (r_state == S_SETTLE && w_settle_end &&
                      r_window == '0)) begin
            r_tie  <= (w_next_a == w_next_b);
            r_resp <= (w_next_a > w_next_b);
        end
    end

    assign bus.busy     = (r_state == S_SETTLE) || (r_state == S_COUNT);
    assign bus.done     = (r_state == S_DONE);
    assign o_ro_enable  = bus.busy;
    assign bus.response = r_resp;
    assign bus.tie      = r_tie;
    assign bus.sat      = r_sat;
    assign bus.count_a  = r_cnt_a;
    assign bus.count_b  = r_cnt_b;

endmodule

// File: tb/tb_ro_pair_counter.sv
// Directed bench for ro_pair_counter: default-width and 4-bit
// counter instances driven by clock-derived oscillator patterns.
module tb_ro_pair_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ro_a = 1'b0;
    logic ro_b = 1'b0;
    logic en16;
    logic en4;

    int a_half = 0;
    int b_half = 0;
    int a_cnt = 0;
    int b_cnt = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ro_pair_counter_if #(.CNT_W(16), .WIN_W(16)) b16 ();
    ro_pair_counter_if #(.CNT_W(4), .WIN_W(16)) b4 ();

    ro_pair_counter #(.CNT_W(16), .WIN_W(16), .SETTLE(4)) dut16 (
        .clk        (clk),
        .rst        (rst),
        .i_ro_a_in  (ro_a),
        .i_ro_b_in  (ro_b),
        .o_ro_enable(en16),
        .bus        (b16.slave)
    );

    ro_pair_counter #(.CNT_W(4), .WIN_W(16), .SETTLE(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .i_ro_a_in  (ro_a),
        .i_ro_b_in  (ro_b),
        .o_ro_enable(en4),
        .bus        (b4.slave)
    );

    // Oscillator models: toggle every a_half/b_half clocks, 0 = static.
    always @(negedge clk) begin
        if (a_half > 0) begin
            a_cnt = a_cnt + 1;
            if (a_cnt >= a_half) begin
                a_cnt = 0;
                ro_a = ~ro_a;
            end
        end
        if (b_half > 0) begin
            b_cnt = b_cnt + 1;
            if (b_cnt >= b_half) begin
                b_cnt = 0;
                ro_b = ~ro_b;
            end
        end
    end

    task automatic measure16(input logic [15:0] win,
                             output int lat, output int en_n);
        @(negedge clk);
        b16.start = 1'b1;
        b16.window = win;
        @(posedge clk);
        #1;
        b16.start = 1'b0;
        lat = -1;
        en_n = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (en16) en_n++;
            if (b16.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({en16, b16.busy, b16.done, b16.response, b16.tie, b16.sat,
             b16.count_a, b16.count_b} !== 38'd0) begin
            errors++;
            $display("FAIL reset16: got %h want 0",
                     {en16, b16.busy, b16.done, b16.response, b16.tie,
                      b16.sat, b16.count_a, b16.count_b});
        end
        checks++;
        if ({en4, b4.busy, b4.done, b4.response, b4.tie, b4.sat,
             b4.count_a, b4.count_b} !== 14'd0) begin
            errors++;
            $display("FAIL reset4: got %h want 0",
                     {en4, b4.busy, b4.done, b4.response, b4.tie,
                      b4.sat, b4.count_a, b4.count_b});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_compare(input int ha, input int hb,
                                input string nm);
        int lat;
        int en_n;
        int lo_a;
        int hi_a;
        int lo_b;
        int hi_b;
        logic exp_resp;
        a_half = ha;
        b_half = hb;
        lo_a = (ha == 2) ? 24 : 15;
        hi_a = (ha == 2) ? 26 : 17;
        lo_b = (hb == 2) ? 24 : 15;
        hi_b = (hb == 2) ? 26 : 17;
        exp_resp = (ha < hb);
        measure16(16'd100, lat, en_n);
        checks++;
        if (lat !== 105) begin
            errors++;
            $display("FAIL %s_latency: got %0d want 105", nm, lat);
        end
        checks++;
        if (!(int'(b16.count_a) >= lo_a && int'(b16.count_a) <= hi_a)) begin
            errors++;
            $display("FAIL %s_count_a: got %0d want %0d..%0d",
                     nm, b16.count_a, lo_a, hi_a);
        end
        checks++;
        if (!(int'(b16.count_b) >= lo_b && int'(b16.count_b) <= hi_b)) begin
            errors++;
            $display("FAIL %s_count_b: got %0d want %0d..%0d",
                     nm, b16.count_b, lo_b, hi_b);
        end
        checks++;
        if ({b16.response, b16.tie, b16.sat, en16, b16.busy} !==
            {exp_resp, 4'b0000}) begin
            errors++;
            $display("FAIL %s_flags: got resp/tie/sat/en/busy=%b want %b",
                     nm, {b16.response, b16.tie, b16.sat, en16, b16.busy},
                     {exp_resp, 4'b0000});
        end
        @(negedge clk);
        checks++;
        if (b16.done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: got %b want 0", nm, b16.done);
        end
        checks++;
        if (b16.response !== exp_resp) begin
            errors++;
            $display("FAIL %s_hold: got %b want %b",
                     nm, b16.response, exp_resp);
        end
    endtask

    task automatic test_static();
        int lat;
        int en_n;
        a_half = 0;
        b_half = 0;
        measure16(16'd50, lat, en_n);
        checks++;
        if (en_n !== 54) begin
            errors++;
            $display("FAIL static_enable: got %0d want 54", en_n);
        end
        checks++;
        if (lat !== 55) begin
            errors++;
            $display("FAIL static_latency: got %0d want 55", lat);
        end
        checks++;
        if ({b16.count_a, b16.count_b, b16.tie, b16.response} !==
            {32'd0, 2'b10}) begin
            errors++;
            $display("FAIL static_result: got a=%0d b=%0d tie=%b resp=%b",
                     b16.count_a, b16.count_b, b16.tie, b16.response);
        end
    endtask

    task automatic test_saturate();
        int lat;
        a_half = 1;
        b_half = 0;
        @(negedge clk);
        b4.start = 1'b1;
        b4.window = 16'd100;
        @(posedge clk);
        #1;
        b4.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (b4.done) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat !== 105) begin
            errors++;
            $display("FAIL sat_latency: got %0d want 105", lat);
        end
        checks++;
        if (b4.count_a !== 4'd15) begin
            errors++;
            $display("FAIL sat_count_a: got %0d want 15", b4.count_a);
        end
        checks++;
        if ({b4.sat, b4.response, b4.tie, b4.count_b} !== 7'b1100000) begin
            errors++;
            $display("FAIL sat_flags: got sat=%b resp=%b tie=%b b=%0d",
                     b4.sat, b4.response, b4.tie, b4.count_b);
        end
        a_half = 0;
    endtask

    task automatic test_abort();
        int dones;
        int lat;
        int en_n;
        a_half = 2;
        b_half = 3;
        @(negedge clk);
        b16.start = 1'b1;
        b16.window = 16'd100;
        @(posedge clk);
        #1;
        b16.start = 1'b0;
        repeat (24) @(negedge clk);
        checks++;
        if (b16.count_a == 16'd0 || en16 !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: got a=%0d en=%b want a>0 en=1",
                     b16.count_a, en16);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({en16, b16.busy, b16.done, b16.count_a, b16.count_b} !==
            35'd0) begin
            errors++;
            $display("FAIL abort_state: got en=%b busy=%b done=%b a=%0d b=%0d",
                     en16, b16.busy, b16.done, b16.count_a, b16.count_b);
        end
        rst = 1'b0;
        dones = 0;
        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            if (b16.done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d want 0", dones);
        end
        measure16(16'd0, lat, en_n);
        checks++;
        if (lat !== 5 || en_n !== 4) begin
            errors++;
            $display("FAIL zero_window: got lat=%0d en=%0d want 5 4",
                     lat, en_n);
        end
        checks++;
        if ({b16.count_a, b16.count_b, b16.tie, b16.response} !==
            {32'd0, 2'b10}) begin
            errors++;
            $display("FAIL zero_result: got a=%0d b=%0d tie=%b resp=%b",
                     b16.count_a, b16.count_b, b16.tie, b16.response);
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        int first;
        a_half = 2;
        b_half = 0;
        @(negedge clk);
        b16.start = 1'b1;
        b16.window = 16'd20;
        @(posedge clk);
        #1;
        b16.start = 1'b0;
        dones = 0;
        first = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (b16.done) begin
                dones++;
                if (first < 0) first = n;
            end
            b16.start = (n == 2 || n == 10);
            b16.window = (n == 2 || n == 10) ? 16'd7 : 16'd0;
        end
        b16.start = 1'b0;
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d want 1", dones);
        end
        checks++;
        if (first !== 25) begin
            errors++;
            $display("FAIL ignore_latency: got %0d want 25", first);
        end
        checks++;
        if (!(b16.count_a >= 16'd4 && b16.count_a <= 16'd6)) begin
            errors++;
            $display("FAIL ignore_count_a: got %0d want 4..6", b16.count_a);
        end
    endtask

    initial begin
        b16.start = 1'b0;
        b16.window = '0;
        b4.start = 1'b0;
        b4.window = '0;
        test_reset();
        test_compare(2, 3, "basic");
        test_compare(3, 2, "swap");
        test_static();
        test_saturate();
        test_abort();
        test_ignore_start();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/ro_pair_counter.md
# ro_pair_counter

Measurement front end for the ring-oscillator entropy/PUF path. It gates a pair of `osc_ring_5` instances through their `enable` inputs and samples their free-running `output_signal` lines into the system clock domain. It counts rising edges of each oscillator over a programmable window and produces a comparison response bit. It sits between the oscillator bank and the key-generation / health-test logic.

## Interface
- `CNT_W`, 16: edge-counter width.
- `WIN_W`, 16: window-length register width.
- `SETTLE`, 4: cycles `ro_enable` is high before counting starts; legal range 2..15.

- `clk` in 1: system clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `start` in 1: measurement request, sampled in IDLE only.
- `window` in WIN_W: count-window length in clk cycles, latched when `start` is accepted.
- `ro_a_in` in 1: asynchronous oscillator A output.
- `ro_b_in` in 1: asynchronous oscillator B output.
- `ro_enable` out 1: drives the `enable` input of both oscillators.
- `busy` out 1: high in SETTLE and COUNT.
- `done` out 1: single-cycle pulse; results valid.
- `response` out 1: 1 iff `count_a > count_b`.
- `tie` out 1: 1 iff `count_a == count_b`.
- `sat` out 1: either counter saturated during the last measurement.
- `count_a`, `count_b` out CNT_W: edge counts of the last measurement.

## Operation
- Each RO input passes through a free-running 3-flop chain s1→s2→s3. A rising edge is `s2 & ~s3`, so at most one edge is counted per clk. Oscillators are expected to be divided below clk/2; faster inputs alias, and that is acceptable.
- FSM states:
  - IDLE: `ro_enable`=0. If `start` is high, latch `window`, clear both counters plus `sat`/`tie`/`response`, and go to SETTLE.
  - SETTLE: `ro_enable`=1, no counting. Stay exactly `SETTLE` cycles, then go to COUNT. If the latched window is 0, go to DONE instead.
  - COUNT: `ro_enable`=1. Each detected rising edge increments its counter. Stay exactly `window` cycles, then go to DONE.
  - DONE: `ro_enable`=0, `done`=1, and `response`/`tie` are registered from the final counts. Unconditionally return to IDLE.
- Counter arithmetic:
  - Counters saturate at 2^CNT_W−1 and do not wrap.
  - Any increment attempt at the maximum value sets `sat`.
- Simultaneous edges on A and B in the same cycle: both counters increment.
- `start` outside IDLE is ignored and is not queued. `start` held high continuously restarts a measurement from every IDLE cycle.
- `count_a`, `count_b`, `response`, `tie` and `sat` hold their values after DONE until the next accepted `start` clears them.
- Reset (any state, including mid-COUNT):
  - Next state is IDLE.
  - All outputs and counters go to 0, `ro_enable`=0, and the synchronizer flops are cleared.
  - No `done` is generated for the aborted measurement.

## Timing
- Reset values: every output is 0.
- `start` is sampled high at edge T. `ro_enable` and `busy` are high from T+1. COUNT spans cycles T+1+SETTLE .. T+SETTLE+window.
- `done` is high for the single cycle T+1+SETTLE+window. In that same cycle `busy` and `ro_enable` are low and results are valid.
- Latency from start acceptance to `done` is SETTLE+window+1 cycles; with window=0 it is SETTLE+1.
- Synchronizer latency: an input rising edge is counted 2–3 cycles after it occurs. Edges arriving in the last 2 cycles of COUNT may be lost, and this loss is by design.
- The earliest next `start` acceptance is the cycle after `done` (IDLE).

## Test plan
- Defaults, window=100. A toggles every 2 clk (rise every 4), B toggles every 3 clk (rise every 6). Required: count_a=25±1, count_b=16±1 (or 17), response=1, tie=0, sat=0. `done` is asserted exactly 105 cycles after start acceptance.
- Same stimulus with A and B swapped. Required: response=0, tie=0, counts swapped.
- Both inputs held static, window=50. Required: count_a=count_b=0, tie=1, response=0. `ro_enable` is high for exactly 54 cycles.
- CNT_W=4, A rises every 2 clk, window=100. Required: count_a=15, sat=1, with no wrap to small values.
- Assert `rst` in the 20th COUNT cycle. Required: next cycle `ro_enable`=0, `busy`=0, all counts 0, and no `done` pulse. A subsequent start with window=0 gives `done` 5 cycles after acceptance with counts 0 and tie=1.
- Pulse `start` during SETTLE and again during COUNT. Required: ignored; exactly one `done`, and the latched window is unchanged.
